// File: rtl/brick_wall.sv
// Brick-breaker wall controller: tracks the brick row, scores hits, counts lives.
// Optional build macro ROW_BONUS_EN: every row refill also adds 10 to the score.
//
// state  | meaning
// IDLE   | waiting for the first launch
// PLAY   | ball in flight, hits and ball losses evaluated
// REFILL | wall cleared; restore bricks and step the row down (one cycle)
// LOST   | ball lost; wait for relaunch or end the game
// OVER   | game finished, outputs frozen until reset
module brick_wall #(
  parameter int START_ROW = 9,
  parameter int MIN_ROW   = 3,
  parameter int LIVES     = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] ball_x,
  input  logic [3:0] ball_y,
  input  logic       ball_valid,
  input  logic       fall_down,
  input  logic       launch,
  output logic [9:0] brick_x,
  output logic [9:0] brick_y,
  output logic       hit,
  output logic [7:0] score,
  output logic [1:0] lives,
  output logic       game_over
);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] PLAY   = 3'd1;
  localparam logic [2:0] REFILL = 3'd2;
  localparam logic [2:0] LOST   = 3'd3;
  localparam logic [2:0] OVER   = 3'd4;

  localparam logic [3:0] START_R    = 4'(START_ROW);
  localparam logic [3:0] MIN_R      = 4'(MIN_ROW);
  localparam logic [1:0] LIVES_INIT = 2'(LIVES);
  localparam logic [9:0] FULL_ROW   = 10'h3FF;

  logic [2:0]  state;
  logic [3:0]  row;
  logic        fall_q;
  logic        fall_rise;
  logic        hit_ok;
  logic [15:0] bx_ext;
  logic [9:0]  bx_clr;

  function automatic logic [7:0] sat_add(input logic [7:0] a, input logic [7:0] b);
    logic [8:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[8] ? 8'hFF : s[7:0];
  endfunction

  assign brick_y   = {6'd0, row};
  assign fall_rise = fall_down & ~fall_q;

  // Zero-padded copy so out-of-range columns (10..15) index safely and read as empty.
  assign bx_ext = {6'd0, brick_x};
  assign hit_ok = ball_valid && (ball_x <= 4'd9) &&
                  (({1'b0, ball_y} + 5'd1) == {1'b0, row}) && bx_ext[ball_x];
  assign bx_clr = brick_x & ~(10'd1 << ball_x);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      brick_x   <= FULL_ROW;
      row       <= START_R;
      score     <= 8'd0;
      lives     <= LIVES_INIT;
      hit       <= 1'b0;
      game_over <= 1'b0;
      fall_q    <= 1'b0;
    end else begin
      fall_q <= fall_down;
      hit    <= 1'b0;
      case (state)
        IDLE: begin
          if (launch) state <= PLAY;
        end
        PLAY: begin
          // A lost ball takes priority over a hit in the same cycle.
          if (fall_rise) begin
            state <= LOST;
            lives <= lives - 2'd1;
          end else if (hit_ok) begin
            brick_x <= bx_clr;
            hit     <= 1'b1;
            score   <= sat_add(score, 8'd1);
            if (bx_clr == 10'd0) state <= REFILL;
          end
        end
        REFILL: begin
          brick_x <= FULL_ROW;
          row     <= (row > MIN_R) ? row - 4'd1 : MIN_R;
`ifdef ROW_BONUS_EN
          score   <= sat_add(score, 8'd10);
`endif
          state   <= PLAY;
        end
        LOST: begin
          if (lives == 2'd0) begin
            state     <= OVER;
            game_over <= 1'b1;
          end else if (launch) begin
            state <= PLAY;
          end
        end
        OVER: begin
          game_over <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_brick_wall.sv
// Scoreboard bench for brick_wall: stimulus pushes expected outputs per cycle,
// a negedge monitor pops and compares them against the DUT.
module tb_brick_wall;

`ifdef ROW_BONUS_EN
  localparam int BONUS = 10;
`else
  localparam int BONUS = 0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] ball_x = 4'd0;
  logic [3:0] ball_y = 4'd0;
  logic       ball_valid = 1'b0;
  logic       fall_down = 1'b0;
  logic       launch = 1'b0;
  logic [9:0] brick_x;
  logic [9:0] brick_y;
  logic       hit;
  logic [7:0] score;
  logic [1:0] lives;
  logic       game_over;

  brick_wall dut (
    .clk(clk), .rst(rst), .ball_x(ball_x), .ball_y(ball_y),
    .ball_valid(ball_valid), .fall_down(fall_down), .launch(launch),
    .brick_x(brick_x), .brick_y(brick_y), .hit(hit), .score(score),
    .lives(lives), .game_over(game_over)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         cyc;
    string      nm;
    logic [9:0] bx;
    logic [3:0] row;
    logic       h;
    logic [7:0] sc;
    logic [1:0] lv;
    logic       go;
  } exp_t;

  exp_t sbq[$];
  int   checks = 0;
  int   errors = 0;

  always @(negedge clk) begin
    while (sbq.size() > 0 && sbq[0].cyc <= cyc) begin
      exp_t e;
      e = sbq.pop_front();
      checks++;
      if (brick_x !== e.bx || brick_y !== {6'd0, e.row} || hit !== e.h ||
          score !== e.sc || lives !== e.lv || game_over !== e.go) begin
        errors++;
        $display("FAIL %s @cyc %0d: got bx=%h by=%0d hit=%b score=%0d lives=%0d go=%b, want bx=%h by=%0d hit=%b score=%0d lives=%0d go=%b",
                 e.nm, cyc, brick_x, brick_y, hit, score, lives, game_over,
                 e.bx, e.row, e.h, e.sc, e.lv, e.go);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d checks=%0d", errors, checks);
    $fatal(1);
  end

  // Small reference state used by the looped row-clearing stimulus.
  logic [9:0] exp_bx;
  logic [3:0] exp_row;
  int         exp_score;
  logic [1:0] exp_lives;
  logic       exp_go;
  logic       fd_lvl;

  function automatic int sat8(input int v);
    return (v > 255) ? 255 : v;
  endfunction

  task automatic drive(input logic l, input logic f, input logic v,
                       input logic [3:0] x, input logic [3:0] y);
    @(posedge clk);
    #1;
    launch = l; fall_down = f; ball_valid = v; ball_x = x; ball_y = y;
  endtask

  task automatic set_rst(input logic v);
    @(posedge clk);
    #1;
    rst = v;
  endtask

  task automatic expect_out(input string nm, input logic [9:0] bx, input logic [3:0] row,
                            input logic h, input logic [7:0] sc, input logic [1:0] lv,
                            input logic go, input int dly);
    exp_t e;
    e.cyc = cyc + dly; e.nm = nm; e.bx = bx; e.row = row; e.h = h;
    e.sc = sc; e.lv = lv; e.go = go;
    sbq.push_back(e);
  endtask

  task automatic model_push(input string nm, input logic h);
    expect_out(nm, exp_bx, exp_row, h, 8'(exp_score), exp_lives, exp_go, 1);
  endtask

  task automatic clear_row(input bit with_refill);
    for (int i = 0; i < 10; i++) begin
      if (exp_bx[i]) begin
        drive(1'b0, fd_lvl, 1'b1, 4'(i), exp_row - 4'd1);
        exp_bx[i] = 1'b0;
        exp_score = sat8(exp_score + 1);
        model_push("row_hit", 1'b1);
      end
    end
    if (with_refill) begin
      drive(1'b0, fd_lvl, 1'b0, 4'd0, 4'd0);
      exp_bx = 10'h3FF;
      if (exp_row > 4'd3) exp_row = exp_row - 4'd1;
      exp_score = sat8(exp_score + BONUS);
      model_push("refill", 1'b0);
    end
  endtask

  initial begin
    int n;
    expect_out("reset_state", 10'h3FF, 4'd9, 1'b0, 8'd0, 2'd3, 1'b0, 1);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    drive(1, 0, 0, 0, 0);  expect_out("launch",        10'h3FF, 9, 0, 8'd0, 3, 0, 1);
    drive(0, 0, 1, 4, 8);  expect_out("first_hit",     10'h3EF, 9, 1, 8'd1, 3, 0, 1);
    drive(0, 0, 1, 4, 8);  expect_out("repeat_strobe", 10'h3EF, 9, 0, 8'd1, 3, 0, 1);
    drive(0, 0, 1, 12, 8); expect_out("x_out_of_range",10'h3EF, 9, 0, 8'd1, 3, 0, 1);
    drive(0, 0, 0, 5, 8);  expect_out("no_valid",      10'h3EF, 9, 0, 8'd1, 3, 0, 1);
    drive(0, 0, 1, 5, 7);  expect_out("wrong_row",     10'h3EF, 9, 0, 8'd1, 3, 0, 1);
    drive(0, 0, 1, 0, 8);  expect_out("hit_c0",        10'h3EE, 9, 1, 8'd2, 3, 0, 1);
    drive(0, 0, 1, 1, 8);  expect_out("hit_c1",        10'h3EC, 9, 1, 8'd3, 3, 0, 1);
    drive(0, 0, 1, 2, 8);  expect_out("hit_c2",        10'h3E8, 9, 1, 8'd4, 3, 0, 1);
    drive(0, 0, 1, 3, 8);  expect_out("hit_c3",        10'h3E0, 9, 1, 8'd5, 3, 0, 1);
    drive(0, 0, 1, 5, 8);  expect_out("hit_c5",        10'h3C0, 9, 1, 8'd6, 3, 0, 1);
    drive(0, 0, 1, 6, 8);  expect_out("hit_c6",        10'h380, 9, 1, 8'd7, 3, 0, 1);
    drive(0, 0, 1, 7, 8);  expect_out("hit_c7",        10'h300, 9, 1, 8'd8, 3, 0, 1);
    drive(0, 0, 1, 8, 8);  expect_out("hit_c8",        10'h200, 9, 1, 8'd9, 3, 0, 1);
    drive(0, 0, 1, 9, 8);  expect_out("hit_last",      10'h000, 9, 1, 8'd10, 3, 0, 1);
    drive(0, 0, 0, 0, 0);  expect_out("refill_row8",   10'h3FF, 8, 0, 8'(10 + BONUS), 3, 0, 1);
    drive(0, 0, 0, 0, 0);  expect_out("play_after_refill", 10'h3FF, 8, 0, 8'(10 + BONUS), 3, 0, 1);

    drive(0, 1, 1, 2, 7);  expect_out("fall_beats_hit",10'h3FF, 8, 0, 8'(10 + BONUS), 2, 0, 1);
    drive(0, 1, 1, 2, 7);  expect_out("lost_ignores_hit", 10'h3FF, 8, 0, 8'(10 + BONUS), 2, 0, 1);
    drive(1, 1, 0, 0, 0);  expect_out("relaunch",      10'h3FF, 8, 0, 8'(10 + BONUS), 2, 0, 1);
    drive(0, 1, 1, 2, 7);  expect_out("fall_level_no_edge", 10'h3FB, 8, 1, 8'(11 + BONUS), 2, 0, 1);

    exp_bx = 10'h3FB; exp_row = 4'd8; exp_score = 11 + BONUS;
    exp_lives = 2'd2; exp_go = 1'b0; fd_lvl = 1'b1;
    clear_row(1'b1);
    n = 1;
    while (!(exp_score == 255 && n >= 8)) begin
      clear_row(1'b1);
      n++;
      if (n == 6) begin
        drive(0, 1, 0, 0, 0);
        expect_out("row_at_min", 10'h3FF, 4'd3, 0, 8'(exp_score), 2, 0, 1);
      end
    end
    drive(0, 1, 0, 0, 0);  expect_out("sat_hold", 10'h3FF, 3, 0, 8'd255, 2, 0, 1);
    drive(0, 1, 1, 0, 2);  expect_out("sat_hit",  10'h3FE, 3, 1, 8'd255, 2, 0, 1);

    drive(0, 0, 0, 0, 0);  expect_out("fall_low",   10'h3FE, 3, 0, 8'd255, 2, 0, 1);
    drive(0, 1, 0, 0, 0);  expect_out("loss2",      10'h3FE, 3, 0, 8'd255, 1, 0, 1);
    drive(1, 1, 0, 0, 0);  expect_out("relaunch2",  10'h3FE, 3, 0, 8'd255, 1, 0, 1);
    drive(0, 0, 0, 0, 0);  expect_out("fall_low2",  10'h3FE, 3, 0, 8'd255, 1, 0, 1);
    drive(0, 1, 0, 0, 0);  expect_out("loss3",      10'h3FE, 3, 0, 8'd255, 0, 0, 1);
    drive(0, 1, 0, 0, 0);  expect_out("game_over",  10'h3FE, 3, 0, 8'd255, 0, 1, 1);
    drive(1, 1, 0, 0, 0);  expect_out("over_launch",10'h3FE, 3, 0, 8'd255, 0, 1, 1);
    drive(0, 1, 1, 1, 2);  expect_out("over_hit",   10'h3FE, 3, 0, 8'd255, 0, 1, 1);
    drive(0, 0, 0, 0, 0);  expect_out("over_fall0", 10'h3FE, 3, 0, 8'd255, 0, 1, 1);
    drive(0, 1, 0, 0, 0);  expect_out("over_fall1", 10'h3FE, 3, 0, 8'd255, 0, 1, 1);
    drive(0, 0, 1, 1, 2);

    set_rst(1'b1);
    expect_out("async_reset", 10'h3FF, 9, 0, 8'd0, 3, 0, 0);
    drive(0, 0, 0, 0, 0);
    set_rst(1'b0);
    drive(1, 0, 0, 0, 0);  expect_out("launch_after_rst", 10'h3FF, 9, 0, 8'd0, 3, 0, 1);

    drive(0, 0, 1, 0, 8);
    @(negedge clk);
    #1 rst = 1'b1;
    expect_out("abort_hit", 10'h3FF, 9, 0, 8'd0, 3, 0, 1);
    set_rst(1'b0);
    drive(1, 0, 0, 0, 0);  expect_out("launch_abort1", 10'h3FF, 9, 0, 8'd0, 3, 0, 1);

    exp_bx = 10'h3FF; exp_row = 4'd9; exp_score = 0;
    exp_lives = 2'd3; exp_go = 1'b0; fd_lvl = 1'b0;
    clear_row(1'b0);
    @(posedge clk);
    @(negedge clk);
    #1 rst = 1'b1;
    expect_out("abort_refill", 10'h3FF, 9, 0, 8'd0, 3, 0, 1);
    set_rst(1'b0);
    drive(1, 0, 0, 0, 0);  expect_out("launch_abort2", 10'h3FF, 9, 0, 8'd0, 3, 0, 1);
    drive(0, 0, 1, 0, 8);  expect_out("hit_after_abort", 10'h3FE, 9, 1, 8'd1, 3, 0, 1);
    drive(0, 0, 0, 0, 0);

    repeat (3) @(posedge clk);
    if (sbq.size() > 0) begin
      $display("FAIL scoreboard_drain: got %0d unchecked entries, want 0", sbq.size());
      checks += sbq.size();
      errors += sbq.size();
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
